ps_64bit: RTL and testbench

- Sequential partial-product generator: the producer end of the z0/z1/z2 interface of the 63-bit output-stage XOR combiner.
- Takes two 64-bit GF(2) polynomial operands a and b.
- Computes three Karatsuba carry-less half products:
  - z0 = a_lo ⊗ b_lo
  - z2 = a_hi ⊗ b_hi
  - z1 = (a_lo^a_hi) ⊗ (b_lo^b_hi)
- Uses DIGIT-bit-per-cycle shift-and-XOR and presents the three 63-bit results under a valid/ready handshake.

---
 rtl/ps64_pkg.sv | 25 ++
 rtl/clmul_digit_step.sv | 20 ++
 rtl/ps_64bit.sv | 111 +++++++++++
 tb/tb_ps_64bit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps64_pkg.sv
// Shared widths, state encoding and a carry-less reference multiply
// for the ps_64bit Karatsuba partial-product generator.
package ps64_pkg;

  localparam int HALF_W = 32;
  localparam int PROD_W = 2 * HALF_W - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [PROD_W-1:0] clmul_ref(
    input logic [HALF_W-1:0] x,
    input logic [HALF_W-1:0] y
  );
    logic [PROD_W-1:0] r;
    r = '0;
    for (int i = 0; i < HALF_W; i++)
      if (y[i]) r = r ^ (PROD_W'(x) << i);
    return r;
  endfunction

endpackage

// File: rtl/clmul_digit_step.sv
// One shift-and-XOR step: folds DIGIT multiplier bits into a
// carry-less accumulator; shifted-out bits are always zero.
module clmul_digit_step
  import ps64_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [PROD_W-1:0] mcand,
  input  logic [DIGIT-1:0]  digit,
  input  logic [PROD_W-1:0] acc,
  output logic [PROD_W-1:0] acc_next
);

  always_comb begin
    acc_next = acc;
    for (int j = 0; j < DIGIT; j++)
      if (digit[j]) acc_next = acc_next ^ (mcand << j);
  end

endmodule

// File: rtl/ps_64bit.sv
// Sequential Karatsuba half products z0/z1/z2 over GF(2), DIGIT bits/cycle.
// Optional PS64_EARLY_DONE_EN: finish once all multipliers drain to zero.
module ps_64bit
  import ps64_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*HALF_W-1:0] a,
  input  logic [2*HALF_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] z0,
  output logic [PROD_W-1:0] z1,
  output logic [PROD_W-1:0] z2,
  output logic              busy
);

  localparam int N   = HALF_W / DIGIT;
  localparam int CW  = $clog2(N + 1);
  localparam int EXT = PROD_W - HALF_W;

  state_t state;
  logic [CW-1:0] count;
  logic [PROD_W-1:0] mcand [3];
  logic [HALF_W-1:0] mult [3];
  logic [PROD_W-1:0] acc [3];
  logic [PROD_W-1:0] acc_next [3];
  logic [HALF_W-1:0] a_lo, a_hi;
  logic [HALF_W-1:0] b_lo, b_hi;
  logic last;

  assign a_lo = a[HALF_W-1:0];
  assign a_hi = a[2*HALF_W-1:HALF_W];
  assign b_lo = b[HALF_W-1:0];
  assign b_hi = b[2*HALF_W-1:HALF_W];

  // lane 0: lo*lo, lane 1: hi*hi, lane 2: mid*mid
  for (genvar i = 0; i < 3; i++) begin : g_lane
    clmul_digit_step #(
      .DIGIT(DIGIT)
    ) u_step (
      .mcand   (mcand[i]),
      .digit   (mult[i][DIGIT-1:0]),
      .acc     (acc[i]),
      .acc_next(acc_next[i])
    );
  end

`ifdef PS64_EARLY_DONE_EN
  logic drained;
  assign drained = ((mult[0] >> DIGIT) |
                    (mult[1] >> DIGIT) |
                    (mult[2] >> DIGIT)) == '0;
  assign last = (count == CW'(N - 1)) || drained;
`else
  assign last = (count == CW'(N - 1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      count <= '0;
      for (int i = 0; i < 3; i++) begin
        mcand[i] <= '0;
        mult[i]  <= '0;
        acc[i]   <= '0;
      end
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            mcand[0] <= {{EXT{1'b0}}, a_lo};
            mcand[1] <= {{EXT{1'b0}}, a_hi};
            mcand[2] <= {{EXT{1'b0}}, a_lo ^ a_hi};
            mult[0]  <= b_lo;
            mult[1]  <= b_hi;
            mult[2]  <= b_lo ^ b_hi;
            for (int i = 0; i < 3; i++) acc[i] <= '0;
            count <= '0;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          for (int i = 0; i < 3; i++) begin
            acc[i]   <= acc_next[i];
            mcand[i] <= mcand[i] << DIGIT;
            mult[i]  <= mult[i] >> DIGIT;
          end
          count <= count + CW'(1);
          if (last) state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_BUSY);
  assign z0 = acc[0];
  assign z2 = acc[1];
  assign z1 = acc[2];

endmodule

// File: tb/tb_ps_64bit.sv
// Directed and random handshake bench for ps_64bit.
// Latency expectation follows PS64_EARLY_DONE_EN when defined.
module tb_ps_64bit;
  import ps64_pkg::*;

  logic clk = 0;
  logic rst;
  logic in_valid;
  logic in_ready;
  logic [63:0] a, b;
  logic out_valid;
  logic out_ready;
  logic [PROD_W-1:0] z0, z1, z2;
  logic busy;

  int n_cmp = 0;
  int n_bad = 0;
  int lat;

  ps_64bit dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .z0(z0), .z1(z1), .z2(z2),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // returns #1 after the accepting edge
  task automatic start_op(input logic [63:0] av, input logic [63:0] bv);
    int t;
    @(negedge clk);
    in_valid = 1; a = av; b = bv;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk); t++;
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_valid(output int l);
    l = 0;
    while (!out_valid && l < 100) begin
      @(posedge clk); #1; l++;
    end
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 0; out_ready = 1; a = '0; b = '0;
    #12;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flags: rdy=%b vld=%b busy=%b want 1 0 0",
               in_ready, out_valid, busy);
    end
    n_cmp++;
    if (z0 !== '0 || z1 !== '0 || z2 !== '0) begin
      n_bad++;
      $display("FAIL reset_z: %h %h %h want 0", z0, z1, z2);
    end
    @(negedge clk); rst = 0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_small();
    start_op(64'h0000_0003_0000_0003, 64'h0000_0003_0000_0003);
    n_cmp++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL small_busy: busy=%b rdy=%b want 1 0", busy, in_ready);
    end
    wait_valid(lat);
    n_cmp++;
    if (lat !== 8) begin
      n_bad++;
      $display("FAIL small_latency: got %0d want 8", lat);
    end
    n_cmp++;
    if (z0 !== 63'h5 || z2 !== 63'h5 || z1 !== 63'h0) begin
      n_bad++;
      $display("FAIL small_z: z0=%h z1=%h z2=%h want 5 0 5", z0, z1, z2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wide();
    start_op({32'h8000_0000, 32'hFFFF_FFFF}, {32'h8000_0000, 32'h0000_0001});
    wait_valid(lat);
    n_cmp++;
    if (z0 !== 63'h0000_0000_FFFF_FFFF) begin
      n_bad++;
      $display("FAIL wide_z0: got %h want 0000_0000_ffff_ffff", z0);
    end
    n_cmp++;
    if (z2 !== 63'h4000_0000_0000_0000) begin
      n_bad++;
      $display("FAIL wide_z2: got %h want 4000_0000_0000_0000", z2);
    end
    n_cmp++;
    if (z1 !== 63'h3FFF_FFFF_FFFF_FFFF) begin
      n_bad++;
      $display("FAIL wide_z1: got %h want 3fff_ffff_ffff_ffff", z1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int bad;
    @(negedge clk); out_ready = 0;
    // lo: 7*3=9, hi: 5*6=1e, mid: 2*5=a
    start_op(64'h0000_0005_0000_0007, 64'h0000_0006_0000_0003);
    wait_valid(lat);
    n_cmp++;
    if (lat !== 8 || z0 !== 63'h9 || z1 !== 63'hA || z2 !== 63'h1E) begin
      n_bad++;
      $display("FAIL bp_result: lat=%0d z0=%h z1=%h z2=%h want 8 9 a 1e",
               lat, z0, z1, z2);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          z0 !== 63'h9 || z1 !== 63'hA || z2 !== 63'h1E) begin
        n_bad++;
        $display("FAIL bp_hold: cyc=%0d vld=%b rdy=%b z0=%h z1=%h z2=%h",
                 i, out_valid, in_ready, z0, z1, z2);
      end
    end
    @(negedge clk); out_ready = 1;
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_handoff: vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    n_cmp++;
    if (z0 !== 63'h9 || z1 !== 63'hA || z2 !== 63'h1E) begin
      n_bad++;
      $display("FAIL bp_retain: z0=%h z1=%h z2=%h want 9 a 1e", z0, z1, z2);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_single: vld=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    start_op(64'h0000_0005_0000_0007, 64'h0000_0006_0000_0003);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rmid_busy: busy=%b want 1", busy);
    end
    rst = 1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
        z0 !== '0 || z1 !== '0 || z2 !== '0) begin
      n_bad++;
      $display("FAIL rmid_async: vld=%b rdy=%b busy=%b z0=%h z1=%h z2=%h",
               out_valid, in_ready, busy, z0, z1, z2);
    end
    @(negedge clk); rst = 0;
    start_op({32'h8000_0000, 32'hFFFF_FFFF}, {32'h8000_0000, 32'h0000_0001});
    wait_valid(lat);
    n_cmp++;
    if (lat !== 8 || z0 !== 63'hFFFF_FFFF ||
        z2 !== 63'h4000_0000_0000_0000 || z1 !== 63'h3FFF_FFFF_FFFF_FFFF) begin
      n_bad++;
      $display("FAIL rmid_after: lat=%0d z0=%h z1=%h z2=%h", lat, z0, z1, z2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_b();
    int want;
`ifdef PS64_EARLY_DONE_EN
    want = 1;
`else
    want = 8;
`endif
    start_op({$urandom, $urandom} | 64'h1, 64'h0);
    wait_valid(lat);
    n_cmp++;
    if (lat !== want) begin
      n_bad++;
      $display("FAIL zero_latency: got %0d want %0d", lat, want);
    end
    n_cmp++;
    if (z0 !== '0 || z1 !== '0 || z2 !== '0) begin
      n_bad++;
      $display("FAIL zero_z: z0=%h z1=%h z2=%h want 0", z0, z1, z2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    localparam int NOPS = 3000;
    logic [PROD_W-1:0] q0[$], q1[$], q2[$];
    logic [PROD_W-1:0] e0, e1, e2;
    logic acc_now, hand_now;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    in_valid = 0;
    while (got < NOPS && cyc < 80000) begin
      @(negedge clk);
      cyc++;
      if (!in_valid && sent < NOPS && $urandom_range(3) != 0) begin
        in_valid = 1;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
      end
      out_ready = ($urandom_range(3) != 0);
      acc_now  = in_valid && in_ready;
      hand_now = out_valid && out_ready;
      @(posedge clk);
      if (acc_now) begin
        q0.push_back(clmul_ref(a[31:0], b[31:0]));
        q2.push_back(clmul_ref(a[63:32], b[63:32]));
        q1.push_back(clmul_ref(a[31:0] ^ a[63:32], b[31:0] ^ b[63:32]));
        sent++;
      end
      if (hand_now) begin
        n_cmp++;
        if (q0.size() == 0) begin
          n_bad++;
          $display("FAIL b2b_dup: result %0d with nothing outstanding", got);
        end else begin
          e0 = q0.pop_front(); e1 = q1.pop_front(); e2 = q2.pop_front();
          if (z0 !== e0 || z1 !== e1 || z2 !== e2) begin
            n_bad++;
            $display("FAIL b2b_data: op %0d got %h %h %h want %h %h %h",
                     got, z0, z1, z2, e0, e1, e2);
          end
        end
        got++;
      end
      #1;
      if (acc_now) in_valid = 0;
    end
    n_cmp++;
    if (got !== NOPS || sent !== NOPS || q0.size() !== 0) begin
      n_bad++;
      $display("FAIL b2b_count: sent=%0d got=%0d pending=%0d want %0d",
               sent, got, q0.size(), NOPS);
    end
    in_valid = 0; out_ready = 1;
  endtask

  initial begin
    test_reset();
    test_small();
    test_wide();
    test_backpressure();
    test_reset_mid();
    test_zero_b();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
